// File: rtl/fir_stream_scheduler.sv
// fir_stream_scheduler
// Framed valid/ready sequencer for the 3-tap FIR datapath. It accepts one input
// sample per handshake and drives the datapath load strobes in the order
// x -> y -> delay line. It holds each filter output until the sink accepts it.
// Optional feature macro: FIR_FLUSH_EN. When it is defined, every non-empty frame
// ends with two zero-input tail samples that drain the delay line.
module fir_stream_scheduler #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [CNT_WIDTH-1:0] frame_len_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 out_last_o,
  output logic                 ld_x_o,
  output logic                 ld_y_o,
  output logic                 ld_delay1_o,
  output logic                 ld_delay2_o,
  output logic                 clr_taps_o,
  output logic                 zero_x_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] sample_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_WAIT_IN = 3'd2,
    S_COMPUTE = 3'd3,
    S_SHIFT   = 3'd4,
    S_OUTPUT  = 3'd5,
`ifdef FIR_FLUSH_EN
    S_FLUSH   = 3'd6,
`endif
    S_DONE    = 3'd7
  } state_e;

  // Per-state output flags, registered alongside the state.
  typedef struct packed {
    logic busy;
    logic clr;
    logic in_ready;
    logic ld_y;
    logic shift;
    logic out_valid;
    logic flush;
    logic done;
  } flags_t;

  state_e                 state_q, state_d;
  flags_t                 flags_q;
  logic                   last_q, last_d;
  logic [CNT_WIDTH-1:0]   frame_len_q;
  logic [CNT_WIDTH-1:0]   in_cnt_q;
  logic [CNT_WIDTH-1:0]   sample_cnt_q;
  logic                   start_acc_s;
  logic                   in_hs_s;
  logic                   out_hs_s;
`ifdef FIR_FLUSH_EN
  logic [1:0]             flush_cnt_q;
`endif

  // Output flags that a given state presents for its whole duration.
  function automatic flags_t flags_for(input state_e s);
    flags_t f;
    f      = '0;
    f.busy = (s != S_IDLE);
    case (s)
      S_CLEAR:   f.clr       = 1'b1;
      S_WAIT_IN: f.in_ready  = 1'b1;
      S_COMPUTE: f.ld_y      = 1'b1;
      S_SHIFT:   f.shift     = 1'b1;
      S_OUTPUT:  f.out_valid = 1'b1;
`ifdef FIR_FLUSH_EN
      S_FLUSH:   f.flush     = 1'b1;
`endif
      S_DONE:    f.done      = 1'b1;
      default:   f.busy      = (s != S_IDLE);
    endcase
    return f;
  endfunction

  // An abort cancels any handshake or load in the same cycle.
  assign start_acc_s = (state_q == S_IDLE) && start_i;
  assign in_hs_s     = (state_q == S_WAIT_IN) && in_valid_i && !abort_i;
  assign out_hs_s    = (state_q == S_OUTPUT) && out_ready_i && !abort_i;

  // Next-state selection and the out_last qualifier for the next OUTPUT.
  always_comb begin
    state_d = state_q;
    last_d  = 1'b0;
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d = (frame_len_i == '0) ? S_DONE : S_CLEAR;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CLEAR:   state_d = S_WAIT_IN;
        S_WAIT_IN: begin
          if (in_valid_i) begin
            state_d = S_COMPUTE;
          end else begin
            state_d = S_WAIT_IN;
          end
        end
        S_COMPUTE: state_d = S_SHIFT;
        S_SHIFT:   state_d = S_OUTPUT;
        S_OUTPUT: begin
          if (out_ready_i) begin
            if (in_cnt_q < frame_len_q) begin
              state_d = S_WAIT_IN;
`ifdef FIR_FLUSH_EN
            end else if (flush_cnt_q < 2'd2) begin
              state_d = S_FLUSH;
`endif
            end else begin
              state_d = S_DONE;
            end
          end else begin
            state_d = S_OUTPUT;
          end
        end
`ifdef FIR_FLUSH_EN
        S_FLUSH:   state_d = S_COMPUTE;
`endif
        S_DONE:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
`ifdef FIR_FLUSH_EN
    // The final output is the one produced by the second tail sample.
    last_d = (flush_cnt_q == 2'd2);
`else
    last_d = (in_cnt_q == frame_len_q);
`endif
  end

  // State, registered output flags and frame counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      flags_q      <= '0;
      last_q       <= 1'b0;
      frame_len_q  <= '0;
      in_cnt_q     <= '0;
      sample_cnt_q <= '0;
`ifdef FIR_FLUSH_EN
      flush_cnt_q  <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      flags_q <= flags_for(state_d);
      last_q  <= (state_d == S_OUTPUT) && last_d;
      if (start_acc_s) begin
        frame_len_q  <= frame_len_i;
        in_cnt_q     <= '0;
        sample_cnt_q <= '0;
`ifdef FIR_FLUSH_EN
        flush_cnt_q  <= 2'd0;
`endif
      end else begin
        if (in_hs_s) begin
          in_cnt_q <= in_cnt_q + CNT_ONE;
        end
        // Saturate instead of wrapping so a long frame never reads back small.
        if (out_hs_s && (sample_cnt_q != '1)) begin
          sample_cnt_q <= sample_cnt_q + CNT_ONE;
        end
`ifdef FIR_FLUSH_EN
        if ((state_q == S_FLUSH) && !abort_i) begin
          flush_cnt_q <= flush_cnt_q + 2'd1;
        end
`endif
      end
    end
  end

  // Strobes and valids are masked by abort so an abandoned cycle never touches
  // the datapath and never presents a handshake that will be ignored.
  assign in_ready_o   = flags_q.in_ready & ~abort_i;
  assign ld_x_o       = ((flags_q.in_ready & in_valid_i) | flags_q.flush) & ~abort_i;
  assign ld_y_o       = flags_q.ld_y & ~abort_i;
  assign ld_delay1_o  = flags_q.shift & ~abort_i;
  assign ld_delay2_o  = flags_q.shift & ~abort_i;
  assign clr_taps_o   = flags_q.clr & ~abort_i;
  assign out_valid_o  = flags_q.out_valid & ~abort_i;
  assign out_last_o   = flags_q.out_valid & last_q & ~abort_i;
`ifdef FIR_FLUSH_EN
  assign zero_x_o     = flags_q.flush & ~abort_i;
`else
  assign zero_x_o     = 1'b0;
`endif
  assign busy_o       = flags_q.busy;
  assign done_o       = flags_q.done;
  assign sample_cnt_o = sample_cnt_q;

endmodule

// File: tb/tb_fir_stream_scheduler.sv
// Testbench for fir_stream_scheduler. It contains a behavioural FIR datapath
// that is driven by the strobes. It checks cycle timing against the documented
// schedule and checks the filter outputs against a plain convolution of the
// samples that were accepted. It runs with or without FIR_FLUSH_EN.
`timescale 1ns/1ps
module tb_fir_stream_scheduler;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef FIR_FLUSH_EN
  localparam int TAIL = 2;
`else
  localparam int TAIL = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_ni, start, abort, in_valid, out_ready;
  logic [CW-1:0] frame_len;
  logic [7:0]    in_data;
  logic          in_ready, out_valid, out_last, ld_x, ld_y, ld_delay1, ld_delay2;
  logic          clr_taps, zero_x, busy, done;
  logic [CW-1:0] sample_cnt;
  logic [14:0]   outs;

  fir_stream_scheduler #(.CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .abort_i(abort),
    .frame_len_i(frame_len), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_last_o(out_last),
    .ld_x_o(ld_x), .ld_y_o(ld_y), .ld_delay1_o(ld_delay1), .ld_delay2_o(ld_delay2),
    .clr_taps_o(clr_taps), .zero_x_o(zero_x), .busy_o(busy), .done_o(done),
    .sample_cnt_o(sample_cnt)
  );

  assign outs = {in_ready, out_valid, out_last, ld_x, ld_y, ld_delay1, ld_delay2,
                 clr_taps, zero_x, busy, done, sample_cnt};

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Single comparison point: counts the check and reports a mismatch.
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Behavioural datapath plus output and input scoreboarding, evaluated mid-cycle.
  int dp_x, dp_d1, dp_d2, dp_y;
  int got_y[$];
  bit got_last[$];
  int seen_in[$];
  int done_cnt;

  always @(negedge clk) begin
    if (rst_ni) begin
      if (out_valid && out_ready) begin
        got_y.push_back(dp_y);
        got_last.push_back(out_last);
      end
      if (in_valid && in_ready) seen_in.push_back(int'(in_data));
      if (done) done_cnt++;
      if (ld_x || ld_y || ld_delay1 || ld_delay2)
        check_eq("strobe_exclusive", 32'(ld_x) + 32'(ld_y) + 32'(ld_delay1 | ld_delay2), 32'd1);
      if (ld_delay1 || ld_delay2) check_eq("delay_pair", 32'(ld_delay1), 32'(ld_delay2));
      if (out_last) check_eq("last_has_valid", 32'(out_valid), 32'd1);
      if (clr_taps) begin
        dp_x = 0; dp_d1 = 0; dp_d2 = 0;
      end
      if (ld_x) dp_x = zero_x ? 0 : int'(in_data);
      if (ld_y) dp_y = dp_x + dp_d1 + dp_d2;
      if (ld_delay2) dp_d2 = dp_d1;
      if (ld_delay1) dp_d1 = dp_x;
    end
  end

  function automatic bit on_slot(input int r, input int off, input int n);
    return (r >= off) && (((r - off) % 4) == 0) && (((r - off) / 4) < n);
  endfunction

  task automatic clear_score();
    got_y.delete(); got_last.delete(); seen_in.delete(); done_cnt = 0;
  endtask

  // Full-rate frame. Every output is compared each cycle with the documented schedule.
  task automatic timing_run(input int len, input bit poke);
    int n, done_at;
    bit e_ldx, e_zero;
    n       = (len == 0) ? 0 : len + TAIL;
    done_at = (len == 0) ? 1 : 4 * n + 2;
    clear_score();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int r = 0; r <= done_at + 1; r++) begin
      start     = (r == 0) || (poke && (r == 4));
      frame_len = (r == 0) ? CW'(len) : CW'(7);
      in_data   = 8'((r + 2) / 4);
      @(negedge clk);
      e_ldx  = on_slot(r, 2, n);
      e_zero = e_ldx && (((r - 2) / 4) >= len);
      check_eq($sformatf("L%0d_ld_x@%0d", len, r), 32'(ld_x), 32'(e_ldx));
      check_eq($sformatf("L%0d_zero_x@%0d", len, r), 32'(zero_x), 32'(e_zero));
      check_eq($sformatf("L%0d_in_ready@%0d", len, r), 32'(in_ready), 32'(e_ldx && !e_zero));
      check_eq($sformatf("L%0d_ld_y@%0d", len, r), 32'(ld_y), 32'(on_slot(r, 3, n)));
      check_eq($sformatf("L%0d_ld_d1@%0d", len, r), 32'(ld_delay1), 32'(on_slot(r, 4, n)));
      check_eq($sformatf("L%0d_out_valid@%0d", len, r), 32'(out_valid), 32'(on_slot(r, 5, n)));
      check_eq($sformatf("L%0d_out_last@%0d", len, r), 32'(out_last),
               32'(on_slot(r, 5, n) && ((r - 5) / 4 == n - 1)));
      check_eq($sformatf("L%0d_clr@%0d", len, r), 32'(clr_taps), 32'((r == 1) && (len > 0)));
      check_eq($sformatf("L%0d_done@%0d", len, r), 32'(done), 32'(r == done_at));
      check_eq($sformatf("L%0d_busy@%0d", len, r), 32'(busy), 32'((r >= 1) && (r <= done_at)));
      @(posedge clk); #1;
    end
    start = 1'b0;
    check_eq($sformatf("L%0d_sample_cnt", len), 32'(sample_cnt), 32'((n > CNT_MAX) ? CNT_MAX : n));
  endtask

  // Random handshakes. Outputs are compared with a convolution of the accepted samples.
  task automatic rand_frame(input int len, input int pv, input int pr);
    int n, e, c;
    n = (len == 0) ? 0 : len + TAIL;
    clear_score();
    start = 1'b1; frame_len = CW'(len); in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    c = 0;
    while (done_cnt == 0 && c < 4000) begin
      start     = ($urandom_range(0, 15) == 0);
      frame_len = CW'($urandom_range(0, CNT_MAX));
      in_valid  = ($urandom_range(0, 99) < pv);
      out_ready = ($urandom_range(0, 99) < pr);
      in_data   = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_eq("rf_done_once", 32'(done_cnt), 32'd1);
    check_eq("rf_busy_after", 32'(busy), 32'd0);
    check_eq("rf_in_count", 32'(seen_in.size()), 32'(len));
    check_eq("rf_out_count", 32'(got_y.size()), 32'(n));
    for (int k = 0; k < got_y.size() && k < n; k++) begin
      e = 0;
      for (int j = 0; j < 3; j++)
        if ((k - j >= 0) && (k - j < seen_in.size())) e += seen_in[k - j];
      check_eq($sformatf("rf_y[%0d]", k), 32'(got_y[k]), 32'(e));
      check_eq($sformatf("rf_last[%0d]", k), 32'(got_last[k]), 32'(k == n - 1));
    end
    check_eq("rf_sample_cnt", 32'(sample_cnt), 32'((n > CNT_MAX) ? CNT_MAX : n));
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c;
    c = 0;
    while (done_cnt == 0 && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check_eq({tag, "_done_seen"}, 32'(done_cnt), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_y[5];
    int ov_cnt, strb_cnt;
    bit found;
    exp_y = '{1, 3, 6, 5, 3};
    rst_ni = 1'b0; start = 1'b0; abort = 1'b0; frame_len = '0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = 8'd0; done_cnt = 0;
    #12;
    check_eq("reset_outputs", 32'(outs), 32'd0);
    @(posedge clk); #1 rst_ni = 1'b1;
    @(posedge clk); #1;

    // Length 3 at full rate. A start pulse with a new length is ignored mid-frame.
    timing_run(3, 1'b1);
    check_eq("L3_y_count", 32'(got_y.size()), 32'(3 + TAIL));
    for (int k = 0; k < got_y.size() && k < 3 + TAIL; k++)
      check_eq($sformatf("L3_y[%0d]", k), 32'(got_y[k]), 32'(exp_y[k]));

    // Empty frame.
    timing_run(0, 1'b0);

    // Output stall for 7 cycles at the first OUTPUT.
    clear_score();
    in_valid = 1'b1; out_ready = 1'b0; start = 1'b1; frame_len = CW'(1);
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (out_valid) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check_eq("stall_reached_output", 32'(found), 32'd1);
    ov_cnt = 32'(out_valid); strb_cnt = 0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1 out_ready = (i == 7);
      @(negedge clk);
      ov_cnt += 32'(out_valid);
      strb_cnt += 32'(ld_x | ld_y | ld_delay1 | ld_delay2 | clr_taps);
      if (i == 3) check_eq("stall_cnt_held", 32'(sample_cnt), 32'd0);
    end
    check_eq("stall_valid_cycles", 32'(ov_cnt), 32'd8);
    check_eq("stall_no_strobes", 32'(strb_cnt), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("stall_valid_dropped", 32'(out_valid), 32'd0);
    check_eq("stall_cnt_once", 32'(sample_cnt), 32'd1);
    wait_done("stall", 100);

    // Abort in COMPUTE of the second of four samples.
    clear_score();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int r = 0; r <= 20; r++) begin
      start = (r == 0); frame_len = CW'(4); abort = (r == 7);
      @(negedge clk);
      if (r == 6) check_eq("abort_second_ldx", 32'(ld_x), 32'd1);
      if (r == 7) check_eq("abort_ldy_masked", 32'(ld_y), 32'd0);
      if (r == 8) begin
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_in_ready", 32'(in_ready), 32'd0);
        check_eq("abort_sample_cnt", 32'(sample_cnt), 32'd1);
      end
      @(posedge clk); #1;
    end
    abort = 1'b0; in_valid = 1'b0;
    check_eq("abort_no_done", 32'(done_cnt), 32'd0);
    check_eq("abort_idle", 32'(busy), 32'd0);
    check_eq("abort_cnt_holds", 32'(sample_cnt), 32'd1);

    // Asynchronous reset while an output is waiting.
    clear_score();
    in_valid = 1'b1; out_ready = 1'b0; start = 1'b1; frame_len = CW'(2);
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (out_valid) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check_eq("arst_reached_output", 32'(found), 32'd1);
    #2 rst_ni = 1'b0;
    #1 check_eq("arst_outputs_zero", 32'(outs), 32'd0);
    @(posedge clk); #1 rst_ni = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check_eq("arst_idle_busy", 32'(busy), 32'd0);
    check_eq("arst_idle_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Randomised frames; the last one is long enough to saturate sample_cnt with tails.
    for (int f = 0; f < 24; f++) begin
      if (f == 23) rand_frame(CNT_MAX, 100, 100);
      else rand_frame($urandom_range(0, 6), $urandom_range(30, 100), $urandom_range(30, 100));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
